// File: rtl/core_pkg.sv
// Shared core constants: PC-unit state encoding, default width and vectors.
// Imported by the PC unit, fetch and CSR logic.
package core_pkg;

  localparam int CORE_XLEN = 32;

  localparam logic [31:0] CORE_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] CORE_TRAP_VECTOR  = 32'h0000_0100;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic int inc_bytes(input int ialign);
    return ialign / 8;
  endfunction

endpackage

// File: rtl/core_pc_align_chk.sv
// Instruction-alignment check for a fetch target address.
// Pure combinational; shared by redirect, JALR and trap-vector paths.
module core_pc_align_chk
  import core_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int IALIGN = 32
) (
  input  logic [XLEN-1:0] target,
  output logic            aligned
);

  localparam logic [XLEN-1:0] MASK =
    XLEN'(inc_bytes(IALIGN) - 1);

  assign aligned = ((target & MASK) == '0);

endmodule

// File: rtl/core_pc_unit.sv
// Program-counter unit: holds the fetch address and offers it over
// valid/ready; applies trap > redirect > stall > advance, plus halt.
module core_pc_unit
  import core_pkg::*;
#(
  parameter int              XLEN         = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = CORE_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = CORE_TRAP_VECTOR,
  parameter int              IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            trap_valid,
  input  logic            halt_req,
  input  logic            resume,
  output logic            halted,
  output logic            upd_done,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  localparam logic [XLEN-1:0] INC =
    XLEN'(inc_bytes(IALIGN));

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            upd_q, upd_d;
  logic            merr_q, merr_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic            aligned;
  logic            xfer;

  core_pc_align_chk #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_align (
    .target  (redir_pc),
    .aligned (aligned)
  );

  assign pc_valid = (state_q == ST_RUN);
  assign halted   = (state_q == ST_HALT);
  assign xfer     = pc_valid & pc_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    upd_d   = 1'b0;
    merr_d  = 1'b0;
    maddr_d = maddr_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (trap_valid) begin
          pc_d  = TRAP_VECTOR;
          upd_d = 1'b1;
        end else if (redir_valid && aligned) begin
          pc_d  = redir_pc;
          upd_d = 1'b1;
        end else if (redir_valid) begin
          merr_d  = 1'b1;
          maddr_d = redir_pc;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (xfer) begin
          pc_d  = pc_q + INC;
          upd_d = 1'b1;
        end
        // halt takes effect after this cycle's PC update
        if (halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (trap_valid) begin
          pc_d    = TRAP_VECTOR;
          upd_d   = 1'b1;
          state_d = ST_RUN;
        end else if (resume && !halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      upd_q   <= 1'b0;
      merr_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      upd_q   <= upd_d;
      merr_q  <= merr_d;
      maddr_q <= maddr_d;
    end
  end

  assign pc_out        = pc_q;
  assign upd_done      = upd_q;
  assign misalign_err  = merr_q;
  assign misalign_addr = maddr_q;

endmodule

// File: tb/tb_core_pc_unit.sv
// Scoreboard bench for core_pc_unit: directed vectors on IALIGN=32 and
// IALIGN=16 instances, expected outputs queued and checked by a monitor.
module tb_core_pc_unit;

  typedef struct packed {
    logic        sel;
    logic [31:0] pc;
    logic        v;
    logic        h;
    logic        u;
    logic        m;
    logic [31:0] a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst32 = 1'b1;
  logic        rst16 = 1'b1;
  logic        pc_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        trap_valid = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;

  logic [31:0] pc32, pc16, ma32, ma16;
  logic        v32, v16, h32, h16, u32, u16, m32, m16;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   vec = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  core_pc_unit #(.IALIGN(32)) dut32 (
    .clk(clk), .rst(rst32),
    .pc_out(pc32), .pc_valid(v32), .pc_ready(pc_ready),
    .stall(stall), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .trap_valid(trap_valid),
    .halt_req(halt_req), .resume(resume),
    .halted(h32), .upd_done(u32),
    .misalign_err(m32), .misalign_addr(ma32)
  );

  core_pc_unit #(.IALIGN(16)) dut16 (
    .clk(clk), .rst(rst16),
    .pc_out(pc16), .pc_valid(v16), .pc_ready(pc_ready),
    .stall(stall), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .trap_valid(trap_valid),
    .halt_req(halt_req), .resume(resume),
    .halted(h16), .upd_done(u16),
    .misalign_err(m16), .misalign_addr(ma16)
  );

  // drive one cycle of inputs and queue the state expected after the edge
  task automatic s(
    input logic        sel,
    input logic        r,
    input logic        rdy,
    input logic        st,
    input logic        rv,
    input logic [31:0] rpc,
    input logic        tv,
    input logic        hr,
    input logic        rs,
    input logic [31:0] e_pc,
    input logic        e_v,
    input logic        e_h,
    input logic        e_u,
    input logic        e_m,
    input logic [31:0] e_a
  );
    exp_t e;
    @(negedge clk);
    rst32       = sel ? 1'b1 : r;
    rst16       = sel ? r : 1'b1;
    pc_ready    = rdy;
    stall       = st;
    redir_valid = rv;
    redir_pc    = rpc;
    trap_valid  = tv;
    halt_req    = hr;
    resume      = rs;
    e = '{sel: sel, pc: e_pc, v: e_v, h: e_h,
          u: e_u, m: e_m, a: e_a};
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        vec++;
        if (e.sel)
          act = '{sel: 1'b1, pc: pc16, v: v16, h: h16,
                  u: u16, m: m16, a: ma16};
        else
          act = '{sel: 1'b0, pc: pc32, v: v32, h: h32,
                  u: u32, m: m32, a: ma32};
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL vec%0d: got pc=%h v=%b h=%b u=%b m=%b a=%h, exp pc=%h v=%b h=%b u=%b m=%b a=%h",
                   vec, act.pc, act.v, act.h, act.u, act.m, act.a,
                   e.pc, e.v, e.h, e.u, e.m, e.a);
        end
      end
    end
  end

  initial begin : stim
    // IALIGN=32 instance: reset, boot, advance
    s(0,1,1,0,0,0,0,0,0, 32'h0,   0,0,0,0,0);
    s(0,0,1,0,0,0,0,0,0, 32'h0,   1,0,0,0,0);
    s(0,0,1,0,0,0,0,0,0, 32'h4,   1,0,1,0,0);
    s(0,0,1,0,0,0,0,0,0, 32'h8,   1,0,1,0,0);
    // fetch back-pressure
    for (int i = 0; i < 5; i++)
      s(0,0,0,0,0,0,0,0,0, 32'h8, 1,0,0,0,0);
    // redirect beats stall and ready
    s(0,0,1,1,1,32'h200,0,0,0, 32'h200, 1,0,1,0,0);
    // misaligned redirect also cancels the transfer
    s(0,0,1,0,1,32'h202,0,0,0, 32'h200, 1,0,0,1,32'h202);
    s(0,0,0,0,0,0,0,0,0, 32'h200, 1,0,0,0,32'h202);
    // trap beats redirect
    s(0,0,0,0,1,32'h300,1,0,0, 32'h100, 1,0,1,0,32'h202);
    // halt after this cycle's advance
    s(0,0,1,0,0,0,0,1,0, 32'h104, 0,1,1,0,32'h202);
    // HALT ignores redirect (even misaligned) and stall
    s(0,0,1,1,1,32'h402,0,0,0, 32'h104, 0,1,0,0,32'h202);
    s(0,0,1,0,0,0,0,1,1, 32'h104, 0,1,0,0,32'h202);
    s(0,0,0,0,0,0,0,0,1, 32'h104, 1,0,0,0,32'h202);
    s(0,0,0,0,0,0,0,1,0, 32'h104, 0,1,0,0,32'h202);
    // trap leaves HALT
    s(0,0,0,0,0,0,1,0,0, 32'h100, 1,0,1,0,32'h202);
    // trap + halt_req in RUN
    s(0,0,1,0,1,32'h500,1,1,0, 32'h100, 0,1,1,0,32'h202);
    // reset mid-HALT
    s(0,1,1,0,0,0,0,0,0, 32'h0,   0,0,0,0,0);
    s(0,0,0,0,0,0,0,0,0, 32'h0,   1,0,0,0,0);
    // wrap-around
    s(0,0,0,0,1,32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC, 1,0,1,0,0);
    s(0,0,1,0,0,0,0,0,0, 32'h0,   1,0,1,0,0);
    // IALIGN=16 instance
    s(1,1,0,0,0,0,0,0,0, 32'h0,   0,0,0,0,0);
    s(1,0,0,0,0,0,0,0,0, 32'h0,   1,0,0,0,0);
    s(1,0,0,0,1,32'h202,0,0,0, 32'h202, 1,0,1,0,0);
    s(1,0,1,0,0,0,0,0,0, 32'h204, 1,0,1,0,0);
    s(1,0,1,0,1,32'h201,0,0,0, 32'h204, 1,0,0,1,32'h201);
    s(1,0,0,0,0,0,0,0,0, 32'h204, 1,0,0,0,32'h201);
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued, exp 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
